// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain
// A chain of DEPTH register stages, WIDTH bits each, with one valid bit per
// stage. Valid/ready handshake on both ends. Empty stages accept
// unconditionally, so bubbles close up without waiting for the consumer.
// A global halt freezes every stage. A synchronous flush clears every valid
// bit. o_count reports how many stages currently hold valid data.
module pipe_reg_chain #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_halt,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_q,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [CW-1:0]    o_count
);

  // Stage 0 is on the input side; stage DEPTH-1 drives o_q/o_valid.
  logic [WIDTH-1:0] d    [DEPTH];
  logic [DEPTH-1:0] v;

  // Load enable per stage, and what each stage would capture when enabled.
  logic [DEPTH-1:0] en;
  logic [DEPTH-1:0] in_v;
  logic [WIDTH-1:0] in_d [DEPTH];

  // Load enables ripple from the output side toward the input side.
  // A stage may load when it is empty or when its successor is loading.
  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    en            = '0;
    en[DEPTH-1]   = ~v[DEPTH-1] | i_ready;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      en[k] = ~v[k] | en[k+1];
    end
  end

  // Incoming word for each stage: upstream for stage 0, predecessor otherwise.
  always_comb begin
    in_v[0] = i_valid;
    in_d[0] = i_d;
    for (int k = 1; k < DEPTH; k++) begin
      in_v[k] = v[k-1];
      in_d[k] = d[k-1];
    end
  end

  // Valid bits: flush clears them, halt freezes them, otherwise enabled
  // stages take their predecessor's valid bit.
  // NOTE: sequential state uses non-blocking assignments, so every stage samples its predecessor's pre-edge value and the shift is simultaneous.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      v <= '0;
    end else if (i_flush) begin
      v <= '0;
    end else if (!i_halt) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (en[k]) begin
          v[k] <= in_v[k];
        end
      end
    end
  end

  // Payload registers: loaded only when an enabled stage receives a valid
  // word, so an invalid slot keeps its last data. Flush leaves data alone.
  // NOTE: the payload array is reset as well, because o_q must read zero after reset rather than stale or X contents.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        d[k] <= '0;
      end
    end else if (!i_flush && !i_halt) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (en[k] && in_v[k]) begin
          d[k] <= in_d[k];
        end
      end
    end
  end

  // Occupancy: population count of the valid bits, registered state only.
  always_comb begin
    o_count = '0;
    for (int k = 0; k < DEPTH; k++) begin
      o_count = o_count + CW'(v[k]);
    end
  end

  // Handshake outputs. Halt hides the output word and refuses input;
  // flush refuses input but still shows the pre-flush output valid.
  always_comb begin
    o_ready = en[0] & ~i_halt & ~i_flush;
    o_valid = v[DEPTH-1] & ~i_halt;
    o_q     = d[DEPTH-1];
  end

endmodule
